// File: rtl/bbqm_queue_ctrl.sv
// bbqm_queue_ctrl -- sequencing controller for the bank-queue wait-time datapath.
//
// Counts customers from the entry (back) and exit (front) photocells, holds the
// active teller count, drives Pcount/Tcount to the external wait-time ROM and
// registers the BCD digits it returns. Tracks EMPTY/QUEUED/FULL, defers teller
// reconfiguration until the queue drains and keeps sticky error flags.
//
// Optional build macro: BBQM_DEBOUNCE_EN
//   When defined, each synchronized sensor passes through a filter that only
//   changes its level after DEB_CYCLES consecutive cycles at the new value.
//   Edge detection then runs on the filtered level (DEB_CYCLES extra latency).
//   When undefined, edge detection runs on the synchronizer output directly.

module bbqm_queue_ctrl #(
  parameter int unsigned MAX_P      = 7,
  parameter int unsigned DEB_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       back_sensor,
  input  logic       front_sensor,
  input  logic [1:0] Tcount_in,
  input  logic       Tcount_load,
  input  logic       err_clr,
  input  logic [3:0] Wtime1_in,
  input  logic [3:0] Wtime2_in,
  output logic [3:0] Pcount,
  output logic [1:0] Tcount,
  output logic [3:0] Wtime1,
  output logic [3:0] Wtime2,
  output logic       wtime_valid,
  output logic       empty_flag,
  output logic       full_flag,
  output logic       ovf_err,
  output logic       udf_err,
  output logic       cfg_err,
  output logic       cfg_pending
);

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_QUEUED = 2'd1,
    ST_FULL   = 2'd2
  } state_e;

  localparam logic [3:0] MAX_PC = 4'(MAX_P);

  // Marker block present only for unsupported parameter values (counter is
  // 4 bits wide and the filter needs at least one stable cycle).
  if (!(MAX_P >= 1 && MAX_P <= 15 && DEB_CYCLES >= 1)) begin : g_bad_params
  end

  // ---------------------------------------------------------------------------
  // Sensor front end: bit 0 = back (entry), bit 1 = front (exit)
  // ---------------------------------------------------------------------------
  logic [1:0] sens_raw;
  logic [1:0] sync0_q, sync1_q;
  logic [1:0] lvl;
  logic [1:0] lvl_prev_q;
  logic [1:0] evt_q;
  logic       entry_evt, exit_evt;

  assign sens_raw = {front_sensor, back_sensor};

  // Two-flop synchronizer for both asynchronous photocells.
  // NOTE: every register in this block has an async reset and is assigned
  // with <= so all flops sample the same pre-edge values; there are no
  // memory arrays here, so resetting everything costs nothing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync0_q <= '0;
      sync1_q <= '0;
    end else begin
      sync0_q <= sens_raw;
      sync1_q <= sync0_q;
    end
  end

`ifdef BBQM_DEBOUNCE_EN
  localparam int unsigned DEB_W = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

  logic [DEB_W-1:0] deb_cnt_q [2];
  logic [1:0]       filt_q;

  // Saturating stability counters: the filtered level flips only after the
  // synchronized level has disagreed with it for DEB_CYCLES cycles in a row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_q <= '0;
      for (int i = 0; i < 2; i++) deb_cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync1_q[i] == filt_q[i]) begin
          deb_cnt_q[i] <= '0;
        end else if (deb_cnt_q[i] == DEB_LAST) begin
          filt_q[i]    <= sync1_q[i];
          deb_cnt_q[i] <= '0;
        end else begin
          deb_cnt_q[i] <= deb_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign lvl = filt_q;
`else
  assign lvl = sync1_q;
`endif

  // Registered rising-edge detect: a held level yields exactly one event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lvl_prev_q <= '0;
      evt_q      <= '0;
    end else begin
      lvl_prev_q <= lvl;
      evt_q      <= lvl & ~lvl_prev_q;
    end
  end

  assign entry_evt = evt_q[0];
  assign exit_evt  = evt_q[1];

  // ---------------------------------------------------------------------------
  // Occupancy counter and queue state
  // ---------------------------------------------------------------------------
  state_e     state_q, state_d;
  logic [3:0] pcount_q, pcount_d;
  logic       empty_q, full_q;
  logic       ovf_set, udf_set;

  // Next occupancy from the event pair; counter never wraps.
  // NOTE: every output of a combinational block gets a default first so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    pcount_d = pcount_q;
    ovf_set  = 1'b0;
    udf_set  = 1'b0;
    unique case ({entry_evt, exit_evt})
      2'b10: begin
        if (state_q != ST_FULL) pcount_d = pcount_q + 4'd1;
        else                    ovf_set  = 1'b1;
      end
      2'b01: begin
        if (state_q != ST_EMPTY) pcount_d = pcount_q - 4'd1;
        else                     udf_set  = 1'b1;
      end
      2'b11: begin
        // Simultaneous entry and exit is net zero, except that an empty queue
        // cannot release anyone first, so the arrival stands.
        if (state_q == ST_EMPTY) pcount_d = 4'd1;
      end
      default: ;
    endcase
  end

  // Next state follows the next occupancy.
  always_comb begin
    if (pcount_d == 4'd0)        state_d = ST_EMPTY;
    else if (pcount_d == MAX_PC) state_d = ST_FULL;
    else                         state_d = ST_QUEUED;
  end

  // State, occupancy and the registered status flags move together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_EMPTY;
      pcount_q <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pcount_q <= pcount_d;
      empty_q  <= (state_d == ST_EMPTY);
      full_q   <= (state_d == ST_FULL);
    end
  end

  // ---------------------------------------------------------------------------
  // Teller configuration
  // ---------------------------------------------------------------------------
  logic [1:0] tcount_q, tcount_d;
  logic [1:0] pend_val_q, pend_val_d;
  logic       pend_q, pend_d;
  logic       load_ok, cfg_set;

  assign cfg_set = Tcount_load && (Tcount_in == 2'd0);
  assign load_ok = Tcount_load && (Tcount_in != 2'd0);

  // A deferred value lands when the queue is (or is becoming) empty; a fresh
  // load is applied at once only if the queue is already empty, otherwise it
  // is parked, replacing any older parked value.
  always_comb begin
    tcount_d   = tcount_q;
    pend_d     = pend_q;
    pend_val_d = pend_val_q;
    if (pend_q && (state_q == ST_EMPTY || state_d == ST_EMPTY)) begin
      tcount_d = pend_val_q;
      pend_d   = 1'b0;
    end
    if (load_ok) begin
      if (state_q == ST_EMPTY) begin
        tcount_d = Tcount_in;
        pend_d   = 1'b0;
      end else begin
        pend_val_d = Tcount_in;
        pend_d     = 1'b1;
      end
    end
  end

  // Teller count and the parked reconfiguration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcount_q   <= 2'b01;
      pend_val_q <= 2'b01;
      pend_q     <= 1'b0;
    end else begin
      tcount_q   <= tcount_d;
      pend_val_q <= pend_val_d;
      pend_q     <= pend_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Wait-time capture: the ROM answers combinationally from Pcount/Tcount, so
  // its digits are taken one edge after either input to it changed.
  // ---------------------------------------------------------------------------
  logic       upd_q;
  logic [3:0] wtime1_q, wtime2_q;
  logic       wvalid_q;

  // Remember that the ROM address moved, then capture its answer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      upd_q    <= 1'b0;
      wtime1_q <= '0;
      wtime2_q <= '0;
      wvalid_q <= 1'b0;
    end else begin
      upd_q    <= (pcount_d != pcount_q) || (tcount_d != tcount_q);
      wvalid_q <= upd_q;
      if (upd_q) begin
        wtime1_q <= Wtime1_in;
        wtime2_q <= Wtime2_in;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky errors: a new error event outranks a coincident clear.
  // ---------------------------------------------------------------------------
  logic ovf_q, udf_q, cfg_q;

  // Error flags hold until err_clr; the set term wins a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
      cfg_q <= 1'b0;
    end else begin
      ovf_q <= (ovf_q & ~err_clr) | ovf_set;
      udf_q <= (udf_q & ~err_clr) | udf_set;
      cfg_q <= (cfg_q & ~err_clr) | cfg_set;
    end
  end

  assign Pcount      = pcount_q;
  assign Tcount      = tcount_q;
  assign Wtime1      = wtime1_q;
  assign Wtime2      = wtime2_q;
  assign wtime_valid = wvalid_q;
  assign empty_flag  = empty_q;
  assign full_flag   = full_q;
  assign ovf_err     = ovf_q;
  assign udf_err     = udf_q;
  assign cfg_err     = cfg_q;
  assign cfg_pending = pend_q;

endmodule

// File: tb/tb_bbqm_queue_ctrl.sv
// tb_bbqm_queue_ctrl -- directed, table-driven bench for bbqm_queue_ctrl.
// The wait-time ROM is modelled here as 3 * ceil(Pcount / Tcount) minutes,
// in BCD. Build with BBQM_DEBOUNCE_EN defined to exercise the debounce filter.

module tb_bbqm_queue_ctrl;

  localparam int unsigned DEB = 4;
`ifdef BBQM_DEBOUNCE_EN
  localparam int X  = DEB;       // extra latency from the filter
  localparam int PW = DEB + 2;   // sensor pulse width that survives the filter
`else
  localparam int X  = 0;
  localparam int PW = 1;
`endif
  localparam int SETTLE = 10 + 2 * X;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       back_sensor, front_sensor;
  logic [1:0] Tcount_in;
  logic       Tcount_load, err_clr;
  logic [3:0] Wtime1_in, Wtime2_in;
  logic [3:0] Pcount;
  logic [1:0] Tcount;
  logic [3:0] Wtime1, Wtime2;
  logic       wtime_valid, empty_flag, full_flag;
  logic       ovf_err, udf_err, cfg_err, cfg_pending;

  always #5 clk = ~clk;

  bbqm_queue_ctrl #(.MAX_P(7), .DEB_CYCLES(DEB)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .back_sensor  (back_sensor),
    .front_sensor (front_sensor),
    .Tcount_in    (Tcount_in),
    .Tcount_load  (Tcount_load),
    .err_clr      (err_clr),
    .Wtime1_in    (Wtime1_in),
    .Wtime2_in    (Wtime2_in),
    .Pcount       (Pcount),
    .Tcount       (Tcount),
    .Wtime1       (Wtime1),
    .Wtime2       (Wtime2),
    .wtime_valid  (wtime_valid),
    .empty_flag   (empty_flag),
    .full_flag    (full_flag),
    .ovf_err      (ovf_err),
    .udf_err      (udf_err),
    .cfg_err      (cfg_err),
    .cfg_pending  (cfg_pending)
  );

  // External lookup ROM model.
  function automatic logic [7:0] rom(input logic [3:0] p, input logic [1:0] t);
    int w;
    if (p == 4'd0 || t == 2'd0) return 8'h00;
    w = 3 * ((int'(p) + int'(t) - 1) / int'(t));
    return {4'(w / 10), 4'(w % 10)};
  endfunction

  assign {Wtime2_in, Wtime1_in} = rom(Pcount, Tcount);

  // Stimulus codes {back, front, load} and flag codes
  // {empty, full, ovf, udf, cfg, pending}.
  localparam logic [2:0] NONE = 3'b000, ENT = 3'b100, EXT = 3'b010,
                         BOTH = 3'b110, LD  = 3'b001;
  localparam logic [5:0] F_0 = 6'b000000, F_E = 6'b100000, F_F = 6'b010000,
                         F_O = 6'b001000, F_U = 6'b000100, F_C = 6'b000010,
                         F_P = 6'b000001;

  typedef struct {
    logic [2:0] stim;
    logic [1:0] tin;
    logic       clr;
    logic [3:0] pc;
    logic [1:0] tc;
    logic [7:0] wt;
    logic [5:0] fl;
  } vec_t;

  localparam int NV = 47;
  vec_t vecs [NV];

  int n_vec = 0;
  int n_err = 0;

  function automatic vec_t mk(input logic [2:0] stim, input logic [1:0] tin,
                              input logic clr, input logic [3:0] pc,
                              input logic [1:0] tc, input logic [7:0] wt,
                              input logic [5:0] fl);
    vec_t v;
    v.stim = stim; v.tin = tin; v.clr = clr;
    v.pc = pc; v.tc = tc; v.wt = wt; v.fl = fl;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] pc,
                           input logic [1:0] tc, input logic [7:0] wt,
                           input logic vld, input logic [5:0] fl);
    check({tag, ".Pcount"},      Pcount,           pc);
    check({tag, ".Tcount"},      Tcount,           tc);
    check({tag, ".Wtime"},       {Wtime2, Wtime1}, wt);
    check({tag, ".wtime_valid"}, wtime_valid,      vld);
    check({tag, ".empty_flag"},  empty_flag,       fl[5]);
    check({tag, ".full_flag"},   full_flag,        fl[4]);
    check({tag, ".ovf_err"},     ovf_err,          fl[3]);
    check({tag, ".udf_err"},     udf_err,          fl[2]);
    check({tag, ".cfg_err"},     cfg_err,          fl[1]);
    check({tag, ".cfg_pending"}, cfg_pending,      fl[0]);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One vector: strobes for one cycle, sensors for PW cycles, then settle.
  task automatic apply_vec(input int i);
    vec_t v;
    v = vecs[i];
    back_sensor  = v.stim[2];
    front_sensor = v.stim[1];
    Tcount_load  = v.stim[0];
    Tcount_in    = v.tin;
    err_clr      = v.clr;
    for (int j = 0; j < PW; j++) begin
      @(negedge clk);
      Tcount_load = 1'b0;
      Tcount_in   = 2'd0;
      err_clr     = 1'b0;
    end
    back_sensor  = 1'b0;
    front_sensor = 1'b0;
    cyc(SETTLE);
    check_all($sformatf("v%0d", i), v.pc, v.tc, v.wt, 1'b0, v.fl);
  endtask

  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) apply_vec(i);
  endtask

  // Entry pulse before edge k: Pcount moves at k+3, wtime_valid at k+4.
  task automatic latency_test();
    back_sensor = 1'b1;
    for (int j = 0; j <= 5 + X; j++) begin
      @(negedge clk);
      if (j == PW - 1) back_sensor = 1'b0;
      if (j == 2 + X) check("lat.pc_before", Pcount, 2);
      if (j == 3 + X) begin
        check("lat.pc_update", Pcount, 3);
        check("lat.vld_early", wtime_valid, 0);
      end
      if (j == 4 + X) begin
        check("lat.vld_pulse", wtime_valid, 1);
        check("lat.wtime", {Wtime2, Wtime1}, 8'h09);
      end
      if (j == 5 + X) check("lat.vld_end", wtime_valid, 0);
    end
    cyc(SETTLE);
  endtask

  // Load strobe sampled on the very edge the queue drains: parked, applied next edge.
  task automatic drain_load_test();
    front_sensor = 1'b1;
    for (int j = 0; j <= 5 + X; j++) begin
      @(negedge clk);
      if (j == PW - 1) front_sensor = 1'b0;
      if (j == 2 + X) begin
        Tcount_load = 1'b1;
        Tcount_in   = 2'd1;
      end
      if (j == 3 + X) begin
        Tcount_load = 1'b0;
        Tcount_in   = 2'd0;
        check("drain.pc",      Pcount,      0);
        check("drain.empty",   empty_flag,  1);
        check("drain.pend",    cfg_pending, 1);
        check("drain.tc_hold", Tcount,      3);
      end
      if (j == 4 + X) begin
        check("drain.tc_apply", Tcount,      1);
        check("drain.pend_clr", cfg_pending, 0);
        check("drain.vld_pc",   wtime_valid, 1);
      end
      if (j == 5 + X) check("drain.vld_tc", wtime_valid, 1);
    end
    cyc(SETTLE);
  endtask

  initial begin
    vecs[0]  = mk(ENT,  2'd0, 1'b0, 4'd2, 2'd1, 8'h06, F_0);
    vecs[1]  = mk(ENT,  2'd0, 1'b0, 4'd4, 2'd1, 8'h12, F_0);
    vecs[2]  = mk(ENT,  2'd0, 1'b0, 4'd5, 2'd1, 8'h15, F_0);
    vecs[3]  = mk(ENT,  2'd0, 1'b0, 4'd6, 2'd1, 8'h18, F_0);
    vecs[4]  = mk(ENT,  2'd0, 1'b0, 4'd7, 2'd1, 8'h21, F_F);
    vecs[5]  = mk(ENT,  2'd0, 1'b0, 4'd7, 2'd1, 8'h21, F_F | F_O);
    vecs[6]  = mk(NONE, 2'd0, 1'b1, 4'd7, 2'd1, 8'h21, F_F);
    vecs[7]  = mk(EXT,  2'd0, 1'b0, 4'd6, 2'd1, 8'h18, F_0);
    vecs[8]  = mk(EXT,  2'd0, 1'b0, 4'd5, 2'd1, 8'h15, F_0);
    vecs[9]  = mk(EXT,  2'd0, 1'b0, 4'd4, 2'd1, 8'h12, F_0);
    vecs[10] = mk(EXT,  2'd0, 1'b0, 4'd3, 2'd1, 8'h09, F_0);
    vecs[11] = mk(EXT,  2'd0, 1'b0, 4'd2, 2'd1, 8'h06, F_0);
    vecs[12] = mk(EXT,  2'd0, 1'b0, 4'd1, 2'd1, 8'h03, F_0);
    vecs[13] = mk(EXT,  2'd0, 1'b0, 4'd0, 2'd1, 8'h00, F_E);
    vecs[14] = mk(EXT,  2'd0, 1'b0, 4'd0, 2'd1, 8'h00, F_E | F_U);
    vecs[15] = mk(NONE, 2'd0, 1'b1, 4'd0, 2'd1, 8'h00, F_E);
    vecs[16] = mk(BOTH, 2'd0, 1'b0, 4'd1, 2'd1, 8'h03, F_0);
    vecs[17] = mk(ENT,  2'd0, 1'b0, 4'd2, 2'd1, 8'h06, F_0);
    vecs[18] = mk(ENT,  2'd0, 1'b0, 4'd3, 2'd1, 8'h09, F_0);
    vecs[19] = mk(ENT,  2'd0, 1'b0, 4'd4, 2'd1, 8'h12, F_0);
    vecs[20] = mk(BOTH, 2'd0, 1'b0, 4'd4, 2'd1, 8'h12, F_0);
    vecs[21] = mk(EXT,  2'd0, 1'b0, 4'd3, 2'd1, 8'h09, F_0);
    vecs[22] = mk(EXT,  2'd0, 1'b0, 4'd2, 2'd1, 8'h06, F_0);
    vecs[23] = mk(LD,   2'd3, 1'b0, 4'd2, 2'd1, 8'h06, F_P);
    vecs[24] = mk(EXT,  2'd0, 1'b0, 4'd1, 2'd1, 8'h03, F_P);
    vecs[25] = mk(EXT,  2'd0, 1'b0, 4'd0, 2'd3, 8'h00, F_E);
    vecs[26] = mk(ENT,  2'd0, 1'b0, 4'd1, 2'd3, 8'h03, F_0);
    vecs[27] = mk(LD,   2'd0, 1'b0, 4'd1, 2'd3, 8'h03, F_C);
    vecs[28] = mk(LD,   2'd0, 1'b1, 4'd1, 2'd3, 8'h03, F_C);
    vecs[29] = mk(NONE, 2'd0, 1'b1, 4'd1, 2'd3, 8'h03, F_0);
    vecs[30] = mk(EXT,  2'd0, 1'b0, 4'd0, 2'd3, 8'h00, F_E);
    vecs[31] = mk(LD,   2'd2, 1'b0, 4'd0, 2'd2, 8'h00, F_E);
    vecs[32] = mk(ENT,  2'd0, 1'b0, 4'd1, 2'd2, 8'h03, F_0);
    vecs[33] = mk(ENT,  2'd0, 1'b0, 4'd2, 2'd2, 8'h03, F_0);
    vecs[34] = mk(ENT,  2'd0, 1'b0, 4'd3, 2'd2, 8'h06, F_0);
    vecs[35] = mk(LD,   2'd1, 1'b0, 4'd3, 2'd2, 8'h06, F_P);
    vecs[36] = mk(LD,   2'd3, 1'b0, 4'd3, 2'd2, 8'h06, F_P);
    vecs[37] = mk(EXT,  2'd0, 1'b0, 4'd2, 2'd2, 8'h03, F_P);
    vecs[38] = mk(EXT,  2'd0, 1'b0, 4'd1, 2'd2, 8'h03, F_P);
    vecs[39] = mk(EXT,  2'd0, 1'b0, 4'd0, 2'd3, 8'h00, F_E);
    vecs[40] = mk(ENT,  2'd0, 1'b0, 4'd1, 2'd3, 8'h03, F_0);
    vecs[41] = mk(ENT,  2'd0, 1'b0, 4'd1, 2'd1, 8'h03, F_0);
    vecs[42] = mk(ENT,  2'd0, 1'b0, 4'd2, 2'd1, 8'h06, F_0);
    vecs[43] = mk(ENT,  2'd0, 1'b0, 4'd3, 2'd1, 8'h09, F_0);
    vecs[44] = mk(ENT,  2'd0, 1'b0, 4'd4, 2'd1, 8'h12, F_0);
    vecs[45] = mk(ENT,  2'd0, 1'b0, 4'd5, 2'd1, 8'h15, F_0);
    vecs[46] = mk(LD,   2'd2, 1'b0, 4'd5, 2'd1, 8'h15, F_P);

    rst_n        = 1'b0;
    back_sensor  = 1'b0;
    front_sensor = 1'b0;
    Tcount_in    = 2'd0;
    Tcount_load  = 1'b0;
    err_clr      = 1'b0;
    cyc(3);
    check_all("reset", 4'd0, 2'd1, 8'h00, 1'b0, F_E);
    rst_n = 1'b1;
    cyc(2);

    // A level held high for many cycles counts once.
    back_sensor = 1'b1;
    cyc(12 + X);
    back_sensor = 1'b0;
    cyc(SETTLE);
    check_all("held", 4'd1, 2'd1, 8'h03, 1'b0, F_0);

    run_vecs(0, 0);
    latency_test();
    run_vecs(1, 40);
    drain_load_test();
    run_vecs(41, 46);

    // Asynchronous reset mid-queue with a parked load.
    rst_n = 1'b0;
    #1;
    check_all("async_rst", 4'd0, 2'd1, 8'h00, 1'b0, F_E);
    cyc(2);
    rst_n = 1'b1;
    cyc(SETTLE);
    check_all("post_rst", 4'd0, 2'd1, 8'h00, 1'b0, F_E);

`ifdef BBQM_DEBOUNCE_EN
    // Glitch shorter than the filter window is ignored.
    back_sensor = 1'b1;
    cyc(DEB - 1);
    back_sensor = 1'b0;
    cyc(SETTLE);
    check("deb.glitch_pc", Pcount, 0);
    // A pulse longer than the window counts exactly once.
    back_sensor = 1'b1;
    cyc(DEB + 2);
    back_sensor = 1'b0;
    cyc(SETTLE);
    check("deb.pulse_pc", Pcount, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
